if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RISC core. Sits directly upstream of the decode/register-read stage.
- Owns the PC and the IF/ID pipeline register.
- Talks to instruction memory through a request/response handshake with variable latency and at most one request outstanding.
- Applies stall, flush and branch/jump redirect commands from the hazard/branch logic.

Parameters:
- XLEN, 32, width of PC, addresses and instructions.
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- NOP_INSTR, 32'h0000_0000, value driven on ifid_instr when the slot is empty.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; equals pc while imem_req=1.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  XLEN  response instruction.
- stall  in  1  decode stage cannot accept; hold IF/ID.
- flush  in  1  invalidate IF/ID contents.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  XLEN  new fetch target.
- ifid_valid  out  1  IF/ID slot holds a live instruction.
- ifid_instr  out  XLEN  instruction to decode.
- ifid_pc  out  XLEN  address of ifid_instr.
- ifid_pc_plus4  out  XLEN  ifid_pc+4.
- pc_out  out  XLEN  current fetch PC, for debug.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=0.
  - Skid buffer empty.
  - Reset asserted mid-operation abandons any outstanding request; a late rvalid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, HOLD, DROP.
  - IDLE: imem_req=0. Next cycle goes to REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready, tag=pc, pc<=pc+4, go to WAIT.
  - WAIT: on imem_rvalid with stall=0, load IF/ID (valid=1, instr=rdata, pc=tag, pc_plus4=tag+4) and go to REQ. On imem_rvalid with stall=1, store {rdata, tag} in the skid buffer and go to HOLD.
  - HOLD: imem_req=0. When stall=0, load IF/ID from the skid buffer and go to REQ.
  - DROP: imem_req=0. On imem_rvalid, discard the data and go to REQ.
- IF/ID update rule, every cycle:
  - stall=1: hold all IF/ID fields.
  - stall=0 and no new instruction this cycle: ifid_valid<=0, ifid_instr<=NOP_INSTR (bubble); ifid_pc and ifid_pc_plus4 hold.
- flush:
  - Forces ifid_valid<=0 and ifid_instr<=NOP_INSTR that cycle. Overrides stall and any same-cycle load.
  - Does not change pc, state or the skid buffer.
- Redirect (highest priority, any state except IDLE):
  - pc<=redirect_pc, ifid_valid<=0, ifid_instr<=NOP_INSTR, skid buffer cleared.
  - In REQ: the request still presents the old pc that cycle. If imem_ready=1, go to DROP; else stay in REQ (next request uses redirect_pc).
  - In WAIT with imem_rvalid=0: go to DROP.
  - In WAIT with imem_rvalid=1: data discarded, go to REQ.
  - In HOLD: go to REQ.
  - In DROP: stay in DROP; if imem_rvalid=1 that same cycle, go to REQ.
  - Redirect in IDLE is ignored.
- Arithmetic: pc+4 and tag+4 wrap modulo 2^XLEN (0xFFFF_FFFC+4=0). redirect_pc[1:0] is forced to 00.
- Throughput: one instruction per 2 cycles with zero-wait memory (ready=1, rvalid the cycle after acceptance). Latency from request acceptance to ifid_valid is 1 cycle plus memory latency.
- imem_rvalid outside WAIT/DROP is ignored.

Test Plan:
- Release reset at t0; ready=1; rvalid 1 cycle after accept; rdata=addr^32'hA5A5_0000 -> imem_addr sequence 0,4,8 in REQ cycles; ifid_pc 0,4,8 with ifid_instr A5A5_0000, A5A5_0004, A5A5_0008; ifid_pc_plus4 = ifid_pc+4.
- Hold stall=1 for 3 cycles starting when the response for addr 8 arrives -> IF/ID keeps pc 4; state HOLD, imem_req=0; one cycle after stall drops, ifid_pc=8, then imem_addr=C.
- Redirect to 0x100 while in WAIT for addr 0xC, delay rvalid 2 cycles -> returned word discarded; ifid_valid=0; next imem_addr=0x100; ifid_pc=0x100 after response.
- Redirect to 0x200 in the same cycle as rvalid -> ifid_valid=0; next imem_addr=0x200, no DROP cycle. Redirect during REQ with ready=1 -> DROP state, the next response is ignored.
- flush=1 with stall=1 while ifid_valid=1 -> ifid_valid=0, ifid_instr=0; pc unchanged. pc=0xFFFF_FFFC accepted -> pc wraps to 0.
- Assert reset while in WAIT, then deliver rvalid during reset and in IDLE -> all outputs at reset values; first request after reset at RESET_PC; stray rdata never reaches IF/ID.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage pipeline.
//
// Owns the fetch PC and the IF/ID pipeline register. Fetches through a
// request/response instruction-memory handshake with variable latency and at
// most one request outstanding. A one-entry skid buffer holds a response that
// arrives while decode is stalled. Stall, flush and branch/jump redirect
// commands come from the hazard/branch logic.
//
// Ports:
//   clk            pipeline clock, rising edge
//   reset          asynchronous active-low reset
//   imem_req       fetch request valid (asserted only in REQ)
//   imem_addr      fetch address, equals pc_out
//   imem_ready     memory accepts the request this cycle
//   imem_rvalid    response data valid
//   imem_rdata     response instruction
//   stall          decode cannot accept; IF/ID holds
//   flush          invalidate IF/ID contents this cycle
//   redirect_valid branch/jump taken
//   redirect_pc    new fetch target (bits [1:0] forced to 0)
//   ifid_valid     IF/ID slot holds a live instruction
//   ifid_instr     instruction to decode (NOP_INSTR when empty)
//   ifid_pc        address of ifid_instr
//   ifid_pc_plus4  ifid_pc + 4
//   pc_out         current fetch PC, for debug
module if_stage #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [XLEN-1:0]   NOP_INSTR = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [XLEN-1:0] pc_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;

  logic            redir;
  logic [XLEN-1:0] redir_target;
  logic            load;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] load_pc;

  assign redir        = redirect_valid && (state_q != S_IDLE);
  assign redir_target = redirect_pc & ~XLEN'(3);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tag_d        = tag_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    load         = 1'b0;
    load_instr   = imem_rdata;
    load_pc      = tag_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      // The request in flight this cycle still carries the old pc even when
      // redirecting; if it gets accepted its response must be dropped.
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redir_target;
          if (imem_ready) state_d = S_DROP;
        end else if (imem_ready) begin
          tag_d   = pc_q;
          pc_d    = pc_q + XLEN'(4);
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redir_target;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          if (!stall) begin
            load    = 1'b1;
            state_d = S_REQ;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = tag_q;
            state_d      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_target;
          state_d = S_REQ;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = skid_instr_q;
          load_pc    = skid_pc_q;
          state_d    = S_REQ;
        end
      end

      S_DROP: begin
        if (redirect_valid) pc_d = redir_target;
        if (imem_rvalid)    state_d = S_REQ;
      end

      default: state_d = S_IDLE;
    endcase

    if (redir) begin
      skid_instr_d = '0;
      skid_pc_d    = '0;
    end
  end

  // IF/ID: flush/redirect kill the slot, stall holds it, otherwise it takes
  // the new instruction or becomes a bubble (pc fields keep their value).
  always_comb begin
    ifid_valid_d    = ifid_valid_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    if (flush || redir) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (!stall) begin
      if (load) begin
        ifid_valid_d    = 1'b1;
        ifid_instr_d    = load_instr;
        ifid_pc_d       = load_pc;
        ifid_pc_plus4_d = load_pc + XLEN'(4);
      end else begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      tag_q           <= '0;
      skid_instr_q    <= '0;
      skid_pc_q       <= '0;
      ifid_valid_q    <= 1'b0;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      tag_q           <= tag_d;
      skid_instr_q    <= skid_instr_d;
      skid_pc_q       <= skid_pc_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
    end
  end

  assign imem_req      = (state_q == S_REQ);
  assign imem_addr     = pc_q;
  assign pc_out        = pc_q;
  assign ifid_valid    = ifid_valid_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: transaction-level reference model plus a memory
// responder with configurable ready rate and latency, directed scenarios with
// literal expectations, then randomized stall/flush/redirect/reset traffic.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] pc_out;

  if_stage #(.XLEN(32), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: fetch progress as flags (waiting for the first cycle
  // after reset, a request outstanding, its response to be discarded, a
  // response parked while decode stalls).
  bit          m_started, m_out, m_discard, m_held;
  logic [31:0] m_pc, m_tag, m_held_instr, m_held_pc;
  bit          m_v;
  logic [31:0] m_instr, m_ipc, m_ipc4;
  bit          acc;
  logic [31:0] acc_addr;

  // Memory responder
  bit          mem_busy;
  int unsigned mem_cnt;
  logic [31:0] mem_addr;
  int unsigned g_rdy_pct = 100, g_lat_min = 0, g_lat_max = 0;
  bit          g_stray = 1'b0, g_force_rv = 1'b0;

  function automatic bit m_req();
    return m_started && !m_out && !m_held;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_out = 0; m_discard = 0; m_held = 0;
    m_pc = RPC; m_tag = '0; m_held_instr = '0; m_held_pc = '0;
    m_v = 0; m_instr = NOP; m_ipc = '0; m_ipc4 = '0;
    mem_busy = 0; mem_cnt = 0; acc = 0;
  endtask

  task automatic model_update();
    bit          req, ld, redir;
    logic [31:0] lpc, linstr, tgt;
    acc = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    req    = m_req();
    ld     = 0;
    lpc    = '0;
    linstr = '0;
    tgt    = redirect_pc & 32'hFFFF_FFFC;
    redir  = m_started && redirect_valid;
    if (!m_started) begin
      m_started = 1;
    end else if (req) begin
      if (imem_ready) begin
        acc = 1; acc_addr = m_pc;
        m_out = 1; m_discard = redir; m_tag = m_pc;
        m_pc = redir ? tgt : m_pc + 32'd4;
      end else if (redir) begin
        m_pc = tgt;
      end
    end else if (m_out) begin
      if (imem_rvalid) begin
        if (!m_discard && !redir) begin
          if (!stall) begin
            ld = 1; linstr = imem_rdata; lpc = m_tag;
          end else begin
            m_held = 1; m_held_instr = imem_rdata; m_held_pc = m_tag;
          end
        end
        m_out = 0; m_discard = 0;
      end else if (redir) begin
        m_discard = 1;
      end
      if (redir) m_pc = tgt;
    end else if (m_held) begin
      if (redir) begin
        m_held = 0; m_pc = tgt;
      end else if (!stall) begin
        ld = 1; linstr = m_held_instr; lpc = m_held_pc; m_held = 0;
      end
    end
    if (flush || redir) begin
      m_v = 0; m_instr = NOP;
    end else if (!stall) begin
      if (ld) begin
        m_v = 1; m_instr = linstr; m_ipc = lpc; m_ipc4 = lpc + 32'd4;
      end else begin
        m_v = 0; m_instr = NOP;
      end
    end
  endtask

  task automatic mem_update();
    if (!rst_n) begin
      mem_busy = 0;
      return;
    end
    if (mem_busy && imem_rvalid && mem_cnt == 0) mem_busy = 0;
    else if (mem_busy && mem_cnt > 0)             mem_cnt--;
    if (acc) begin
      mem_busy = 1;
      mem_addr = acc_addr;
      mem_cnt  = $urandom_range(g_lat_max, g_lat_min);
    end
  endtask

  task automatic compare();
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
    if (m_req()) chk("imem_addr", imem_addr, m_pc);
    chk("pc_out", pc_out, m_pc);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_v});
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_pc_plus4", ifid_pc_plus4, m_ipc4);
  endtask

  // Entered and left at a falling edge.
  task automatic step(input bit st, input bit fl, input bit rd, input logic [31:0] rpc);
    compare();
    stall = st; flush = fl; redirect_valid = rd; redirect_pc = rpc;
    imem_ready = ($urandom_range(99) < g_rdy_pct);
    if (mem_busy && mem_cnt == 0) begin
      imem_rvalid = 1; imem_rdata = mem_addr ^ 32'hA5A5_0000;
    end else if (!mem_busy && (g_force_rv || (g_stray && $urandom_range(3) == 0))) begin
      imem_rvalid = 1; imem_rdata = 32'hDEAD_0000 | $urandom_range(16'hFFFF);
    end else begin
      imem_rvalid = 0; imem_rdata = $urandom;
    end
    @(posedge clk);
    model_update();
    mem_update();
    @(negedge clk);
  endtask

  task automatic idle_steps(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(0, 0, 0, 32'h0);
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = '0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1;

    // Zero-wait streaming
    idle_steps(1);
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    idle_steps(2);
    chk("t1_ifid_pc0", ifid_pc, 32'h0);
    chk("t1_instr0", ifid_instr, 32'hA5A5_0000);
    chk("t1_plus4_0", ifid_pc_plus4, 32'h4);
    chk("t1_addr4", imem_addr, 32'h4);
    idle_steps(2);
    chk("t1_ifid_pc4", ifid_pc, 32'h4);
    chk("t1_instr4", ifid_instr, 32'hA5A5_0004);
    idle_steps(1);

    // Stall while the response for 8 arrives
    for (int unsigned k = 0; k < 3; k++) step(1, 0, 0, 32'h0);
    chk("t2_hold_pc", ifid_pc, 32'h4);
    chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
    idle_steps(1);
    chk("t2_ifid_pc8", ifid_pc, 32'h8);
    chk("t2_instr8", ifid_instr, 32'hA5A5_0008);
    chk("t2_valid", {31'd0, ifid_valid}, 32'd1);
    chk("t2_addrC", imem_addr, 32'hC);

    // Redirect while waiting, response delayed
    g_lat_min = 2; g_lat_max = 2;
    idle_steps(1);
    g_lat_min = 0; g_lat_max = 0;
    step(0, 0, 1, 32'h100);
    chk("t3_valid", {31'd0, ifid_valid}, 32'd0);
    chk("t3_pc", pc_out, 32'h100);
    idle_steps(2);
    chk("t3_req", {31'd0, imem_req}, 32'd1);
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_valid2", {31'd0, ifid_valid}, 32'd0);
    idle_steps(2);
    chk("t3_ifid_pc", ifid_pc, 32'h100);
    chk("t3_instr", ifid_instr, 32'hA5A5_0100);

    // Redirect with rvalid, then redirect on an accepted request
    idle_steps(1);
    step(0, 0, 1, 32'h200);
    chk("t4_valid", {31'd0, ifid_valid}, 32'd0);
    chk("t4_req", {31'd0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    step(0, 0, 1, 32'h300);
    chk("t4_drop_req", {31'd0, imem_req}, 32'd0);
    chk("t4_drop_pc", pc_out, 32'h300);
    idle_steps(1);
    chk("t4_addr300", imem_addr, 32'h300);
    chk("t4_dropped", {31'd0, ifid_valid}, 32'd0);
    idle_steps(2);
    chk("t4_ifid_pc", ifid_pc, 32'h300);

    // Flush with stall; pc wrap; redirect alignment
    g_rdy_pct = 0;
    step(1, 1, 0, 32'h0);
    chk("t5_valid", {31'd0, ifid_valid}, 32'd0);
    chk("t5_instr", ifid_instr, 32'h0);
    chk("t5_ifid_pc", ifid_pc, 32'h300);
    chk("t5_pc", pc_out, 32'h304);
    step(0, 0, 1, 32'hFFFF_FFFC);
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    g_rdy_pct = 100;
    idle_steps(1);
    chk("t5_wrap", pc_out, 32'h0);
    idle_steps(1);
    chk("t5_ifid_top", ifid_pc, 32'hFFFF_FFFC);
    chk("t5_plus4_wrap", ifid_pc_plus4, 32'h0);
    chk("t5_instr_top", ifid_instr, 32'h5A5A_FFFC);
    g_rdy_pct = 0;
    step(0, 0, 1, 32'h0000_0123);
    chk("t5_align", pc_out, 32'h120);

    // Reset while waiting, stray responses during reset and IDLE
    g_rdy_pct = 100; g_lat_min = 3; g_lat_max = 3;
    idle_steps(1);
    chk("t6_wait_pc", pc_out, 32'h124);
    #2;
    rst_n = 0;
    model_reset();
    imem_rvalid = 1; imem_rdata = 32'hBAD0_0124;
    #1;
    chk("t6_rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("t6_rst_instr", ifid_instr, NOP);
    chk("t6_rst_ifid_pc", ifid_pc, 32'h0);
    chk("t6_rst_plus4", ifid_pc_plus4, 32'h0);
    chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
    chk("t6_rst_pc", pc_out, RPC);
    g_force_rv = 1; g_lat_min = 0; g_lat_max = 0;
    @(negedge clk);
    idle_steps(1);
    rst_n = 1;
    idle_steps(1);
    g_force_rv = 0;
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    chk("t6_addr", imem_addr, RPC);
    chk("t6_valid", {31'd0, ifid_valid}, 32'd0);
    idle_steps(2);
    chk("t6_ifid_pc", ifid_pc, RPC);
    chk("t6_instr", ifid_instr, RPC ^ 32'hA5A5_0000);

    // Randomized traffic
    g_rdy_pct = 60; g_lat_min = 0; g_lat_max = 3; g_stray = 1;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rpc;
      rst_n = ($urandom_range(599) != 0);
      rpc = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                     : ($urandom & 32'h0000_0FFF);
      step($urandom_range(9) < 3, $urandom_range(19) == 0,
           $urandom_range(19) == 0, rpc);
    end
    rst_n = 1;
    idle_steps(4);
    compare();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
